fetch_sequencer: RTL

Instruction-fetch and PC-sequencing controller placed directly upstream of the SPARC V8 datapath. It drives the datapath's fetch-side select and enable inputs: PC/nPC initialisation, MAR load, RAM read handshake (MOV/MOC), IR load, and the PC←nPC, nPC←nPC+4 update. It hands each fetched instruction to the execute controller through a start/done handshake. Control outputs are zero outside fetch states, so they can be OR-combined with the execute controller's outputs.

---
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch and PC-sequencing controller for the SPARC V8 datapath.
// Drives fetch-side selects/enables; all controls are zero outside fetch states.
module fetch_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MOC,
  input  logic        Halt,
  input  logic        Exec_done,
  input  logic        Exec_redirect,
  output logic        MAR_enable,
  output logic        IR_enable,
  output logic        PC_enable,
  output logic        nPC_enable,
  output logic        MOV,
  output logic [2:0]  ALU_Mux_A_select,
  output logic [2:0]  ALU_Mux_B_select,
  output logic        ALU_Mux_Op_select,
  output logic        RAM_Mux_Op_select,
  output logic [5:0]  Op5,
  output logic [1:0]  PC_Mux_select,
  output logic        Exec_start,
  output logic        Mem_fault,
  output logic [31:0] Instr_count
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] A_PC   = 3'd1;
  localparam logic [2:0] A_NPC  = 3'd2;
  localparam logic [2:0] B_FOUR = 3'd3;
  localparam logic [2:0] M_ZERO = 3'd5;
  localparam logic [1:0] PCM_NPC = 2'd0;
  localparam logic [1:0] PCM_ALU = 2'd1;

  typedef enum logic [3:0] {
    S_INIT_PC,
    S_INIT_NPC,
    S_FETCH_MAR,
    S_IDLE,
    S_FETCH_READ,
    S_DISPATCH,
    S_EXECUTE,
    S_UPDATE,
    S_FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Sequencing, MOC wait counter, sticky fault and retire counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_INIT_PC;
      wait_cnt    <= '0;
      Mem_fault   <= 1'b0;
      Instr_count <= '0;
    end else begin
      case (state)
        S_INIT_PC:   state <= S_INIT_NPC;
        S_INIT_NPC:  state <= S_FETCH_MAR;
        S_FETCH_MAR: state <= Halt ? S_IDLE : S_FETCH_READ;
        S_IDLE:      if (!Halt) state <= S_FETCH_MAR;
        S_FETCH_READ: begin
          if (MOC) begin
            wait_cnt <= '0;
            state    <= S_DISPATCH;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= '0;
            Mem_fault <= 1'b1;
            state     <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DISPATCH:  state <= S_EXECUTE;
        S_EXECUTE: begin
          if (Exec_done) begin
            Instr_count <= Instr_count + 32'd1;
            state       <= Exec_redirect ? S_FETCH_MAR : S_UPDATE;
          end
        end
        S_UPDATE:    state <= S_FETCH_MAR;
        S_FAULT:     state <= S_FAULT;
        default:     state <= S_INIT_PC;
      endcase
    end
  end

  // Control decode from the state register; IR_enable and the FETCH_MAR
  // halt gating follow their inputs within the cycle.
  always_comb begin
    MAR_enable        = 1'b0;
    IR_enable         = 1'b0;
    PC_enable         = 1'b0;
    nPC_enable        = 1'b0;
    MOV               = 1'b0;
    ALU_Mux_A_select  = 3'd0;
    ALU_Mux_B_select  = 3'd0;
    ALU_Mux_Op_select = 1'b0;
    RAM_Mux_Op_select = 1'b0;
    Op5               = 6'd0;
    PC_Mux_select     = 2'd0;
    Exec_start        = 1'b0;
    case (state)
      S_INIT_PC: begin
        ALU_Mux_A_select = M_ZERO;
        ALU_Mux_B_select = M_ZERO;
        PC_Mux_select    = PCM_ALU;
        PC_enable        = 1'b1;
      end
      S_INIT_NPC: begin
        ALU_Mux_A_select = M_ZERO;
        ALU_Mux_B_select = B_FOUR;
        nPC_enable       = 1'b1;
      end
      S_FETCH_MAR: begin
        if (!Halt) begin
          ALU_Mux_A_select = A_PC;
          ALU_Mux_B_select = M_ZERO;
          MAR_enable       = 1'b1;
        end
      end
      S_FETCH_READ: begin
        MOV       = 1'b1;
        IR_enable = MOC;
      end
      S_DISPATCH: Exec_start = 1'b1;
      S_UPDATE: begin
        ALU_Mux_A_select = A_NPC;
        ALU_Mux_B_select = B_FOUR;
        PC_Mux_select    = PCM_NPC;
        PC_enable        = 1'b1;
        nPC_enable       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
